// File: rtl/pio_arb_pkg.sv
// pio_arb_pkg: shared definitions for the PIO write arbiter.
//   pio_arb_state_t : FSM state encoding (IDLE/WRITE/VERIFY/HOLD)
//   PIO_DATA_ADDR   : PIO data register offset used for every access
//   PIO_BUS_W       : Avalon-MM data bus width of the PIO slave
package pio_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    VERIFY = 2'd2,
    HOLD   = 2'd3
  } pio_arb_state_t;

  localparam logic [1:0] PIO_DATA_ADDR = 2'd0;
  localparam int         PIO_BUS_W     = 32;

endpackage

// File: rtl/pio_write_arbiter_rr_arb2.sv
// rr_arb2: two-input round-robin picker.
//   clk, reset_n : clock, asynchronous active-low reset
//   en           : grant enable; grants and last_grant update only when high
//   req0, req1   : requests
//   gnt0, gnt1   : combinational one-hot grant (both low when en=0 or no request)
// last_grant resets to 1 so requester 0 wins the first tie.
module rr_arb2 (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  logic last_grant;

  // On a tie the requester that did not win last time gets the grant.
  assign gnt0 = en & req0 & (~req1 | last_grant);
  assign gnt1 = en & req1 & (~req0 | ~last_grant);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
    end else if (gnt0 | gnt1) begin
      last_grant <= gnt1;
    end
  end

endmodule

// File: rtl/pio_write_arbiter.sv
// pio_write_arbiter: Avalon-MM master sharing an output PIO between two
// requesters. Round-robin grant, one single-cycle write per grant to PIO
// offset 0, then HOLD_CYCLES idle cycles so each pattern stays visible.
//
// Handshake: a requester holds reqN high until ackN; ackN is a one-cycle
// pulse coincident with the PIO write strobe. Requests are only sampled in
// IDLE; a request dropped after grant still gets its captured byte written.
//
// Ports:
//   clk, reset_n            : clock, asynchronous active-low reset
//   req0/data0/ack0         : requester 0
//   req1/data1/ack1         : requester 1
//   pio_address, pio_chipselect, pio_write_n, pio_writedata : PIO slave bus
//   pio_readdata            : PIO readback (read only with PIO_ARB_READBACK_EN)
//   busy                    : high in every state except IDLE
//   last_written            : byte of the most recent completed write
//   err                     : sticky readback mismatch (PIO_ARB_READBACK_EN only)
//   state_dbg               : current FSM state encoding
//
// Build option: define PIO_ARB_READBACK_EN to add a VERIFY read after each
// write and the sticky err output.
module pio_write_arbiter
  import pio_arb_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int HOLD_CYCLES = 4,
  parameter int HOLD_W      = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req0,
  input  logic [DATA_W-1:0]    data0,
  output logic                 ack0,
  input  logic                 req1,
  input  logic [DATA_W-1:0]    data1,
  output logic                 ack1,
  output logic [1:0]           pio_address,
  output logic                 pio_chipselect,
  output logic                 pio_write_n,
  output logic [PIO_BUS_W-1:0] pio_writedata,
  input  logic [PIO_BUS_W-1:0] pio_readdata,
  output logic                 busy,
  output logic [DATA_W-1:0]    last_written,
`ifdef PIO_ARB_READBACK_EN
  output logic                 err,
`endif
  output logic [1:0]           state_dbg
);

  // Entry value of the hold counter; unused when HOLD_CYCLES is 0.
  localparam logic [HOLD_W-1:0] HOLD_LOAD =
    (HOLD_CYCLES > 0) ? HOLD_W'(HOLD_CYCLES - 1) : '0;

  pio_arb_state_t    state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] sel_data;
  logic              gnt0;
  logic              gnt1;

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (state == IDLE),
    .req0    (req0),
    .req1    (req1),
    .gnt0    (gnt0),
    .gnt1    (gnt1)
  );

  assign sel_data  = gnt0 ? data0 : data1;
  assign state_dbg = state;

`ifdef PIO_ARB_READBACK_EN
  logic unused_readdata_hi;
  assign unused_readdata_hi = ^pio_readdata[PIO_BUS_W-1:DATA_W];
`else
  logic unused_readdata;
  assign unused_readdata = ^pio_readdata;
`endif

  // All outputs are registered: each transition loads the output values
  // that belong to the state being entered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      hold_cnt       <= '0;
      wr_data        <= '0;
      pio_address    <= PIO_DATA_ADDR;
      pio_chipselect <= 1'b0;
      pio_write_n    <= 1'b1;
      pio_writedata  <= '0;
      ack0           <= 1'b0;
      ack1           <= 1'b0;
      busy           <= 1'b0;
      last_written   <= '0;
`ifdef PIO_ARB_READBACK_EN
      err            <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (gnt0 | gnt1) begin
            state          <= WRITE;
            wr_data        <= sel_data;
            pio_address    <= PIO_DATA_ADDR;
            pio_chipselect <= 1'b1;
            pio_write_n    <= 1'b0;
            pio_writedata  <= {{(PIO_BUS_W-DATA_W){1'b0}}, sel_data};
            ack0           <= gnt0;
            ack1           <= gnt1;
            busy           <= 1'b1;
          end
        end

        WRITE: begin
          ack0         <= 1'b0;
          ack1         <= 1'b0;
          last_written <= wr_data;
`ifdef PIO_ARB_READBACK_EN
          // Chipselect stays high with write_n released: a read of offset 0.
          state        <= VERIFY;
          pio_write_n  <= 1'b1;
`else
          pio_chipselect <= 1'b0;
          pio_write_n    <= 1'b1;
          if (HOLD_CYCLES > 0) begin
            state    <= HOLD;
            hold_cnt <= HOLD_LOAD;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
`endif
        end

`ifdef PIO_ARB_READBACK_EN
        VERIFY: begin
          if (pio_readdata[DATA_W-1:0] != wr_data) begin
            err <= 1'b1;
          end
          pio_chipselect <= 1'b0;
          pio_write_n    <= 1'b1;
          if (HOLD_CYCLES > 0) begin
            state    <= HOLD;
            hold_cnt <= HOLD_LOAD;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
`endif

        HOLD: begin
          if (hold_cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end

        default: begin
          state          <= IDLE;
          pio_chipselect <= 1'b0;
          pio_write_n    <= 1'b1;
          busy           <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pio_write_arbiter.sv
// tb_pio_write_arbiter: table-driven vectors plus hand-written multi-cycle
// sequences for pio_write_arbiter, with a write scoreboard (exp_q) fed when
// requests are driven and drained on every PIO write strobe.
module tb_pio_write_arbiter;
  import pio_arb_pkg::*;

  localparam int DATA_W = 8;
  localparam int HOLD   = 4;
`ifdef PIO_ARB_READBACK_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT (HOLD_CYCLES=4) ----------------
  logic              req0 = 1'b0, req1 = 1'b0;
  logic [DATA_W-1:0] data0 = '0, data1 = '0;
  logic              ack0, ack1;
  logic [1:0]        pio_address;
  logic              pio_chipselect, pio_write_n;
  logic [31:0]       pio_writedata, pio_readdata;
  logic              busy;
  logic [DATA_W-1:0] last_written;
  logic [1:0]        state_dbg;
`ifdef PIO_ARB_READBACK_EN
  logic              err;
`endif

  pio_write_arbiter #(.DATA_W(DATA_W), .HOLD_CYCLES(HOLD), .HOLD_W(8)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .data0(data0), .ack0(ack0),
    .req1(req1), .data1(data1), .ack1(ack1),
    .pio_address(pio_address), .pio_chipselect(pio_chipselect),
    .pio_write_n(pio_write_n), .pio_writedata(pio_writedata),
    .pio_readdata(pio_readdata), .busy(busy), .last_written(last_written),
`ifdef PIO_ARB_READBACK_EN
    .err(err),
`endif
    .state_dbg(state_dbg)
  );

  // ---------------- second DUT (HOLD_CYCLES=0) ----------------
  logic              h0_req0 = 1'b0, h0_req1 = 1'b0;
  logic [DATA_W-1:0] h0_data0 = '0, h0_data1 = '0;
  logic              h0_ack0, h0_ack1;
  logic [1:0]        h0_address;
  logic              h0_cs, h0_wn;
  logic [31:0]       h0_writedata, h0_readdata;
  logic              h0_busy;
  logic [DATA_W-1:0] h0_last;
  logic [1:0]        h0_state;
`ifdef PIO_ARB_READBACK_EN
  logic              h0_err;
`endif

  pio_write_arbiter #(.DATA_W(DATA_W), .HOLD_CYCLES(0), .HOLD_W(8)) u_dut_h0 (
    .clk(clk), .reset_n(reset_n),
    .req0(h0_req0), .data0(h0_data0), .ack0(h0_ack0),
    .req1(h0_req1), .data1(h0_data1), .ack1(h0_ack1),
    .pio_address(h0_address), .pio_chipselect(h0_cs),
    .pio_write_n(h0_wn), .pio_writedata(h0_writedata),
    .pio_readdata(h0_readdata), .busy(h0_busy), .last_written(h0_last),
`ifdef PIO_ARB_READBACK_EN
    .err(h0_err),
`endif
    .state_dbg(h0_state)
  );

  // ---------------- PIO register models (zero read latency) ----------------
  logic [31:0] pio_reg, h0_reg;
  logic        force_zero = 1'b0;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pio_reg <= '0;
      h0_reg  <= '0;
    end else begin
      if (pio_chipselect && !pio_write_n) pio_reg <= pio_writedata;
      if (h0_cs && !h0_wn)                h0_reg  <= h0_writedata;
    end
  end
  assign pio_readdata = force_zero ? 32'h0 : pio_reg;
  assign h0_readdata  = h0_reg;

  // ---------------- checking ----------------
  int nvec = 0;
  int nerr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard entry: {expect ack1, byte}.
  logic [DATA_W:0] exp_q[$];

  always @(negedge clk) begin
    if (reset_n && pio_chipselect && !pio_write_n) begin
      if (exp_q.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL sb_unexpected: strobe with data %h, none expected", pio_writedata);
      end else begin
        logic [DATA_W:0] e;
        e = exp_q.pop_front();
        check("sb_data", pio_writedata, {24'h0, e[DATA_W-1:0]});
        check("sb_ack", {30'h0, ack1, ack0}, e[DATA_W] ? 32'd2 : 32'd1);
        check("sb_addr", {30'h0, pio_address}, 32'd0);
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) check("idle_timeout", {31'h0, busy}, 32'd0);
  endtask

  // Counts negedges until a write strobe on the selected DUT (0 main, 1 h0).
  task automatic wait_strobe(input int which, input int bound, output int waited);
    logic seen;
    waited = 0;
    seen = 1'b0;
    while (!seen && waited < bound) begin
      @(negedge clk);
      waited++;
      seen = (which == 0) ? (pio_chipselect && !pio_write_n) : (h0_cs && !h0_wn);
    end
    if (!seen) check("strobe_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic              r0;
    logic              r1;
    logic [DATA_W-1:0] d0;
    logic [DATA_W-1:0] d1;
    logic [DATA_W-1:0] ed;
    logic              ea1;
  } vec_t;
  vec_t tbl[8];

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int w;

    // last_grant starts at 1, so ties go 0,1,0,... from reset.
    tbl[0] = '{1'b1, 1'b0, 8'hA5, 8'h00, 8'hA5, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 8'h11, 8'h22, 8'h22, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 8'h33, 8'h44, 8'h33, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 8'h5A, 8'hC3, 8'hC3, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 8'h77, 8'h88, 8'h88, 1'b1};
    tbl[5] = '{1'b1, 1'b1, 8'h99, 8'h66, 8'h99, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 8'h0F, 8'hF0, 8'hF0, 1'b1};
    tbl[7] = '{1'b1, 1'b0, 8'hFF, 8'h00, 8'hFF, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cs",   {31'h0, pio_chipselect}, 32'd0);
    check("rst_wn",   {31'h0, pio_write_n}, 32'd1);
    check("rst_addr", {30'h0, pio_address}, 32'd0);
    check("rst_wdata", pio_writedata, 32'd0);
    check("rst_ack",  {30'h0, ack1, ack0}, 32'd0);
    check("rst_busy", {31'h0, busy}, 32'd0);
    check("rst_last", {24'h0, last_written}, 32'd0);
    check("rst_state", {30'h0, state_dbg}, 32'd0);
`ifdef PIO_ARB_READBACK_EN
    check("rst_err", {31'h0, err}, 32'd0);
`endif
    reset_n = 1'b1;

    // Table: grant, write strobe one cycle later, then busy through hold.
    for (int i = 0; i < 8; i++) begin
      wait_idle();
      req0 = tbl[i].r0; req1 = tbl[i].r1;
      data0 = tbl[i].d0; data1 = tbl[i].d1;
      exp_q.push_back({tbl[i].ea1, tbl[i].ed});
      @(negedge clk);
      check("v_cs",    {31'h0, pio_chipselect}, 32'd1);
      check("v_wn",    {31'h0, pio_write_n}, 32'd0);
      check("v_wdata", pio_writedata, {24'h0, tbl[i].ed});
      check("v_ack0",  {31'h0, ack0}, {31'h0, ~tbl[i].ea1});
      check("v_ack1",  {31'h0, ack1}, {31'h0, tbl[i].ea1});
      req0 = 1'b0; req1 = 1'b0;
      for (int k = 0; k < HOLD + EXTRA; k++) begin
        @(negedge clk);
        check("v_busy_hold", {31'h0, busy}, 32'd1);
        check("v_no_ack", {30'h0, ack1, ack0}, 32'd0);
        check("v_wn_hold", {31'h0, pio_write_n}, 32'd1);
      end
      check("v_last", {24'h0, last_written}, {24'h0, tbl[i].ed});
      @(negedge clk);
      check("v_busy_idle", {31'h0, busy}, 32'd0);
    end

    // Both held from reset: 11,22,11,22 with strobes HOLD+2 apart.
    do_reset();
    req0 = 1'b1; req1 = 1'b1; data0 = 8'h11; data1 = 8'h22;
    exp_q.push_back({1'b0, 8'h11}); exp_q.push_back({1'b1, 8'h22});
    exp_q.push_back({1'b0, 8'h11}); exp_q.push_back({1'b1, 8'h22});
    wait_strobe(0, 10, w);
    check("rr_first_lat", w, 32'd1);
    for (int k = 0; k < 3; k++) begin
      wait_strobe(0, 20, w);
      check("rr_gap", w, HOLD + 2 + EXTRA);
    end
    req0 = 1'b0; req1 = 1'b0;

    // req1 raised during hold: no strobe until IDLE, then one cycle later.
    wait_idle();
    req0 = 1'b1; data0 = 8'h5C;
    exp_q.push_back({1'b0, 8'h5C});
    wait_strobe(0, 10, w);
    req0 = 1'b0;
    @(negedge clk);
    req1 = 1'b1; data1 = 8'hE7;
    exp_q.push_back({1'b1, 8'hE7});
    wait_strobe(0, 20, w);
    check("hold_ignore_gap", w, HOLD + 1 + EXTRA);
    req1 = 1'b0;

    // HOLD_CYCLES=0: write every 2 cycles, never back-to-back strobes.
    wait_idle();
    h0_req0 = 1'b1; h0_data0 = 8'h3A;
    wait_strobe(1, 10, w);
    check("h0_wdata", h0_writedata, 32'h3A);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("h0_no_consec", {31'h0, h0_wn}, 32'd1);
      wait_strobe(1, 10, w);
      check("h0_gap", w + 1, 2 + EXTRA);
      check("h0_ack0", {31'h0, h0_ack0}, 32'd1);
    end
    h0_req0 = 1'b0;
    repeat (4) @(negedge clk);

    // Reset asserted during the WRITE cycle.
    wait_idle();
    req0 = 1'b1; data0 = 8'hC9;
    exp_q.push_back({1'b0, 8'hC9});
    @(negedge clk);
    req0 = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("mid_cs",    {31'h0, pio_chipselect}, 32'd0);
    check("mid_wn",    {31'h0, pio_write_n}, 32'd1);
    check("mid_wdata", pio_writedata, 32'd0);
    check("mid_ack",   {30'h0, ack1, ack0}, 32'd0);
    check("mid_busy",  {31'h0, busy}, 32'd0);
    check("mid_last",  {24'h0, last_written}, 32'd0);
    check("mid_state", {30'h0, state_dbg}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    req0 = 1'b1; req1 = 1'b1; data0 = 8'h4D; data1 = 8'hB2;
    exp_q.push_back({1'b0, 8'h4D});
    @(negedge clk);
    check("post_rst_tie", pio_writedata, 32'h4D);
    check("post_rst_ack0", {31'h0, ack0}, 32'd1);
    req0 = 1'b0; req1 = 1'b0;

`ifdef PIO_ARB_READBACK_EN
    // Readback mismatch sets sticky err; matching readback leaves it clear.
    wait_idle();
    force_zero = 1'b1;
    req0 = 1'b1; data0 = 8'h3C;
    exp_q.push_back({1'b0, 8'h3C});
    wait_strobe(0, 10, w);
    req0 = 1'b0;
    @(negedge clk);
    check("verify_cs", {31'h0, pio_chipselect}, 32'd1);
    check("verify_wn", {31'h0, pio_write_n}, 32'd1);
    @(negedge clk);
    check("err_set", {31'h0, err}, 32'd1);
    force_zero = 1'b0;
    wait_idle();
    req1 = 1'b1; data1 = 8'h81;
    exp_q.push_back({1'b1, 8'h81});
    wait_strobe(0, 10, w);
    req1 = 1'b0;
    repeat (2) @(negedge clk);
    check("err_sticky", {31'h0, err}, 32'd1);
    do_reset();
    check("err_cleared", {31'h0, err}, 32'd0);
    req0 = 1'b1; data0 = 8'h6E;
    exp_q.push_back({1'b0, 8'h6E});
    wait_strobe(0, 10, w);
    req0 = 1'b0;
    repeat (2) @(negedge clk);
    check("err_match", {31'h0, err}, 32'd0);
`endif

    wait_idle();
    repeat (2) @(negedge clk);
    check("sb_drain", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
